pc_ir_unit: RTL and testbench



---
 rtl/pc_ir_unit_if.sv | 46 ++++
 rtl/pc_ir_unit.sv | 104 ++++++++++
 tb/tb_pc_ir_unit.sv | 376 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pc_ir_unit_if.sv
// pc_ir_unit_if: control, flag and data signals exchanged between the
// multi-cycle core (decoder, ALU, memory, result mux) and pc_ir_unit.
// The master modport is the core side; the slave modport is pc_ir_unit.
interface pc_ir_unit_if #(
  parameter int XLEN = 32
);
  // Decoder controls
  logic            PCUpdate;
  logic            IRWrite;
  logic            beq;
  logic            bne;
  logic            bge;
  logic            blt;

  // ALU flags from the rs1 - rs2 subtraction
  logic            Zero;
  logic            Negative;
  logic            Overflow;

  // Datapath inputs
  logic [XLEN-1:0] PCNext;
  logic [XLEN-1:0] ReadData;

  // Unit outputs
  logic [XLEN-1:0] PC;
  logic [XLEN-1:0] OldPC;
  logic [XLEN-1:0] Instr;
  logic            PCWrite;
  logic            BranchTaken;
  logic [31:0]     FetchCount;
  logic            Misaligned;

  modport master (
    output PCUpdate, IRWrite, beq, bne, bge, blt,
    output Zero, Negative, Overflow,
    output PCNext, ReadData,
    input  PC, OldPC, Instr, PCWrite, BranchTaken, FetchCount, Misaligned
  );

  modport slave (
    input  PCUpdate, IRWrite, beq, bne, bge, blt,
    input  Zero, Negative, Overflow,
    input  PCNext, ReadData,
    output PC, OldPC, Instr, PCWrite, BranchTaken, FetchCount, Misaligned
  );
endinterface

// File: rtl/pc_ir_unit.sv
// pc_ir_unit: program counter, fetch-time PC and instruction register for
// the multi-cycle RISC-V core. Resolves conditional branches from the ALU
// flags, produces the PC write enable and counts instruction fetches.
//
// Optional feature, macro PC_MISALIGN_TRAP_EN: when defined, a PC write to
// a target whose low two bits are not zero is suppressed and the sticky
// Misaligned flag is raised. When undefined, any target is accepted and
// Misaligned is tied low.
module pc_ir_unit #(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic       clk,
  input  logic       reset,
  pc_ir_unit_if.slave bus
);

  localparam logic [XLEN-1:0] NOP_INSTR = XLEN'(32'h0000_0013);

  logic            lt;
  logic            branch_taken;
  logic            pc_update_req;
  logic            trap_block;
  logic            pc_write;

  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] old_pc_q;
  logic [XLEN-1:0] instr_q;
  logic [31:0]     fetch_count_q;
  logic            misaligned_q;

  // Branch resolution and PC write enable, purely combinational
  // NOTE: every signal written here gets a value on every path (assigned
  // unconditionally), so no latch can be inferred.
  always_comb begin
    lt            = bus.Negative ^ bus.Overflow;
    // Strobes are one-hot by contract; ORing keeps the logic well defined
    // even if the decoder misbehaves.
    branch_taken  = (bus.beq & bus.Zero)  |
                    (bus.bne & ~bus.Zero) |
                    (bus.blt & lt)        |
                    (bus.bge & ~lt);
    pc_update_req = bus.PCUpdate | branch_taken;
`ifdef PC_MISALIGN_TRAP_EN
    trap_block    = pc_update_req & (bus.PCNext[1:0] != 2'b00);
`else
    trap_block    = 1'b0;
`endif
    pc_write      = pc_update_req & ~trap_block;
  end

  // Architectural PC register
  // NOTE: state registers use non-blocking assignments so every register
  // samples pre-edge values; OldPC relies on this to capture the old PC.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q <= RESET_PC;
    end else if (pc_write) begin
      pc_q <= bus.PCNext;
    end
  end

  // Instruction register and fetch-time PC, loaded together on IRWrite
  always_ff @(posedge clk) begin
    if (reset) begin
      instr_q  <= NOP_INSTR;
      old_pc_q <= RESET_PC;
    end else if (bus.IRWrite) begin
      instr_q  <= bus.ReadData;
      old_pc_q <= pc_q;
    end
  end

  // Fetch counter, wraps silently modulo 2^32
  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_count_q <= '0;
    end else if (bus.IRWrite) begin
      fetch_count_q <= fetch_count_q + 32'd1;
    end
  end

`ifdef PC_MISALIGN_TRAP_EN
  // Sticky misaligned-target flag; cleared only by reset
  always_ff @(posedge clk) begin
    if (reset) begin
      misaligned_q <= 1'b0;
    end else if (trap_block) begin
      misaligned_q <= 1'b1;
    end
  end
`else
  assign misaligned_q = 1'b0;
`endif

  assign bus.PC          = pc_q;
  assign bus.OldPC       = old_pc_q;
  assign bus.Instr       = instr_q;
  assign bus.FetchCount  = fetch_count_q;
  assign bus.Misaligned  = misaligned_q;
  assign bus.PCWrite     = pc_write;
  assign bus.BranchTaken = branch_taken;

endmodule

// File: tb/tb_pc_ir_unit.sv
// tb_pc_ir_unit: scoreboard bench for pc_ir_unit. A reference model predicts
// the register state for each edge from the applied inputs and pushes it to
// a queue; each scenario task pops and compares after the edge.
module tb_pc_ir_unit;

  localparam int          XLEN     = 32;
  localparam logic [31:0] RESET_PC = 32'h0000_1000;
  localparam logic [31:0] NOP      = 32'h0000_0013;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  pc_ir_unit_if #(.XLEN(XLEN)) bus ();

  pc_ir_unit #(
    .XLEN    (XLEN),
    .RESET_PC(RESET_PC)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  typedef struct {
    logic [31:0] pc;
    logic [31:0] old_pc;
    logic [31:0] instr;
    logic [31:0] fcnt;
    logic        mis;
  } snap_t;

  snap_t       sb_q[$];
  int          vectors     = 0;
  int          miscompares = 0;

  logic [31:0] m_pc;
  logic [31:0] m_old;
  logic [31:0] m_instr;
  logic [31:0] m_cnt;
  logic        m_mis;

  task automatic idle_inputs();
    bus.PCUpdate = 1'b0;
    bus.IRWrite  = 1'b0;
    bus.beq      = 1'b0;
    bus.bne      = 1'b0;
    bus.bge      = 1'b0;
    bus.blt      = 1'b0;
    bus.Zero     = 1'b0;
    bus.Negative = 1'b0;
    bus.Overflow = 1'b0;
    bus.PCNext   = 32'h0;
    bus.ReadData = 32'h0;
  endtask

  // Reference model: advance the expected state for the coming edge
  task automatic predict();
    logic  lt_m, taken_m, upd_m, trap_m;
    snap_t s;
    if (reset) begin
      m_pc    = RESET_PC;
      m_old   = RESET_PC;
      m_instr = NOP;
      m_cnt   = 32'h0;
      m_mis   = 1'b0;
    end else begin
      lt_m    = bus.Negative ^ bus.Overflow;
      taken_m = (bus.beq && bus.Zero) || (bus.bne && !bus.Zero) ||
                (bus.blt && lt_m) || (bus.bge && !lt_m);
      upd_m   = bus.PCUpdate || taken_m;
      trap_m  = 1'b0;
`ifdef PC_MISALIGN_TRAP_EN
      trap_m  = upd_m && (bus.PCNext[1:0] != 2'b00);
      if (trap_m) m_mis = 1'b1;
`endif
      if (bus.IRWrite) begin
        m_instr = bus.ReadData;
        m_old   = m_pc;
        m_cnt   = m_cnt + 32'd1;
      end
      if (upd_m && !trap_m) m_pc = bus.PCNext;
    end
    s.pc = m_pc; s.old_pc = m_old; s.instr = m_instr; s.fcnt = m_cnt; s.mis = m_mis;
    sb_q.push_back(s);
  endtask

  task automatic clock_edge();
    predict();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    snap_t e;
    @(negedge clk);
    reset        = 1'b1;
    bus.PCUpdate = 1'b1;
    bus.IRWrite  = 1'b1;
    bus.beq      = 1'b1;
    bus.Zero     = 1'b1;
    bus.PCNext   = 32'h0000_0044;
    bus.ReadData = 32'hDEAD_BEEF;
    for (int i = 0; i < 2; i++) begin
      clock_edge();
      e = sb_q.pop_front();
      vectors++;
      if (bus.PC !== RESET_PC || bus.PC !== e.pc) begin
        miscompares++; $display("FAIL reset_pc[%0d]: got %h want %h", i, bus.PC, RESET_PC);
      end
      vectors++;
      if (bus.OldPC !== RESET_PC || bus.OldPC !== e.old_pc) begin
        miscompares++; $display("FAIL reset_oldpc[%0d]: got %h want %h", i, bus.OldPC, RESET_PC);
      end
      vectors++;
      if (bus.Instr !== NOP || bus.Instr !== e.instr) begin
        miscompares++; $display("FAIL reset_instr[%0d]: got %h want %h", i, bus.Instr, NOP);
      end
      vectors++;
      if (bus.FetchCount !== 32'h0 || bus.FetchCount !== e.fcnt) begin
        miscompares++; $display("FAIL reset_fcnt[%0d]: got %h want 0", i, bus.FetchCount);
      end
      vectors++;
      if (bus.Misaligned !== 1'b0 || bus.Misaligned !== e.mis) begin
        miscompares++; $display("FAIL reset_mis[%0d]: got %b want 0", i, bus.Misaligned);
      end
    end
    // Combinational outputs follow the inputs even while reset is held
    vectors++;
    if (bus.PCWrite !== 1'b1) begin
      miscompares++; $display("FAIL reset_pcwrite_comb: got %b want 1", bus.PCWrite);
    end
  endtask

  task automatic test_fetch();
    snap_t e;
    @(negedge clk);
    reset = 1'b0;
    idle_inputs();
    bus.PCUpdate = 1'b1;
    bus.PCNext   = 32'h0000_0100;
    clock_edge();
    e = sb_q.pop_front();
    vectors++;
    if (bus.PC !== 32'h100 || bus.PC !== e.pc) begin
      miscompares++; $display("FAIL fetch_setup_pc: got %h want 00000100", bus.PC);
    end
    @(negedge clk);
    idle_inputs();
    bus.IRWrite  = 1'b1;
    bus.PCUpdate = 1'b1;
    bus.PCNext   = 32'h0000_0104;
    bus.ReadData = 32'h00A0_0093;
    #1;
    vectors++;
    if (bus.PCWrite !== 1'b1 || bus.BranchTaken !== 1'b0) begin
      miscompares++; $display("FAIL fetch_comb: got pcw=%b bt=%b want 1/0", bus.PCWrite, bus.BranchTaken);
    end
    clock_edge();
    e = sb_q.pop_front();
    vectors++;
    if (bus.PC !== 32'h104 || bus.PC !== e.pc) begin
      miscompares++; $display("FAIL fetch_pc: got %h want 00000104", bus.PC);
    end
    vectors++;
    if (bus.OldPC !== 32'h100 || bus.OldPC !== e.old_pc) begin
      miscompares++; $display("FAIL fetch_oldpc: got %h want 00000100", bus.OldPC);
    end
    vectors++;
    if (bus.Instr !== 32'h00A0_0093 || bus.Instr !== e.instr) begin
      miscompares++; $display("FAIL fetch_instr: got %h want 00a00093", bus.Instr);
    end
    vectors++;
    if (bus.FetchCount !== 32'd1 || bus.FetchCount !== e.fcnt) begin
      miscompares++; $display("FAIL fetch_fcnt: got %h want 1", bus.FetchCount);
    end
  endtask

  typedef struct {
    logic        beq, bne, blt, bge, z, n, v;
    logic [31:0] next;
    logic        taken;
  } br_t;

  task automatic test_branches();
    br_t   tbl[11];
    snap_t e;
    tbl[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h200, 1'b1};
    tbl[1]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h2F0, 1'b0};
    tbl[2]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h300, 1'b0};
    tbl[3]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h300, 1'b1};
    tbl[4]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'h400, 1'b1};
    tbl[5]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 32'h4F0, 1'b0};
    tbl[6]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h480, 1'b1};
    tbl[7]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 32'h500, 1'b1};
    tbl[8]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 32'h5F0, 1'b0};
    tbl[9]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h540, 1'b1};
    tbl[10] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h600, 1'b0};
    for (int i = 0; i < 11; i++) begin
      @(negedge clk);
      idle_inputs();
      bus.beq      = tbl[i].beq;
      bus.bne      = tbl[i].bne;
      bus.blt      = tbl[i].blt;
      bus.bge      = tbl[i].bge;
      bus.Zero     = tbl[i].z;
      bus.Negative = tbl[i].n;
      bus.Overflow = tbl[i].v;
      bus.PCNext   = tbl[i].next;
      #1;
      vectors++;
      if (bus.BranchTaken !== tbl[i].taken || bus.PCWrite !== tbl[i].taken) begin
        miscompares++;
        $display("FAIL branch_comb[%0d]: got bt=%b pcw=%b want %b", i,
                 bus.BranchTaken, bus.PCWrite, tbl[i].taken);
      end
      clock_edge();
      e = sb_q.pop_front();
      vectors++;
      if (bus.PC !== e.pc) begin
        miscompares++; $display("FAIL branch_pc[%0d]: got %h want %h", i, bus.PC, e.pc);
      end
    end
  endtask

  task automatic test_back_to_back();
    snap_t e;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      idle_inputs();
      bus.IRWrite  = 1'b1;
      bus.PCUpdate = (i != 4);       // last cycle: IR load without PC advance
      bus.PCNext   = m_pc + 32'd4;
      bus.ReadData = $urandom;
      clock_edge();
      e = sb_q.pop_front();
      vectors++;
      if (bus.PC !== e.pc || bus.OldPC !== e.old_pc) begin
        miscompares++;
        $display("FAIL b2b_pc[%0d]: got pc=%h old=%h want pc=%h old=%h", i,
                 bus.PC, bus.OldPC, e.pc, e.old_pc);
      end
      vectors++;
      if (bus.Instr !== e.instr || bus.FetchCount !== e.fcnt) begin
        miscompares++;
        $display("FAIL b2b_ir[%0d]: got ir=%h cnt=%h want ir=%h cnt=%h", i,
                 bus.Instr, bus.FetchCount, e.instr, e.fcnt);
      end
    end
  endtask

  task automatic test_counter_wrap();
    snap_t e;
    @(negedge clk);
    idle_inputs();
    force dut.fetch_count_q = 32'hFFFF_FFFF;
    #1;
    release dut.fetch_count_q;
    m_cnt = 32'hFFFF_FFFF;
    vectors++;
    if (bus.FetchCount !== 32'hFFFF_FFFF) begin
      miscompares++; $display("FAIL wrap_preload: got %h want ffffffff", bus.FetchCount);
    end
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      bus.IRWrite  = 1'b1;
      bus.ReadData = 32'h0000_1000 + 32'(i);
      clock_edge();
      e = sb_q.pop_front();
      vectors++;
      if (bus.FetchCount !== 32'(i) || bus.FetchCount !== e.fcnt) begin
        miscompares++; $display("FAIL wrap_fcnt[%0d]: got %h want %h", i, bus.FetchCount, e.fcnt);
      end
    end
  endtask

  task automatic test_misaligned();
    snap_t       e;
    logic [31:0] nexts[3];
    logic        use_beq[3];
    logic        pcw_exp[3];
    nexts[0] = 32'h102; use_beq[0] = 1'b0;
    nexts[1] = 32'h108; use_beq[1] = 1'b0;
    nexts[2] = 32'h10A; use_beq[2] = 1'b1;
`ifdef PC_MISALIGN_TRAP_EN
    pcw_exp[0] = 1'b0; pcw_exp[1] = 1'b1; pcw_exp[2] = 1'b0;
`else
    pcw_exp[0] = 1'b1; pcw_exp[1] = 1'b1; pcw_exp[2] = 1'b1;
`endif
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      idle_inputs();
      bus.PCUpdate = !use_beq[i];
      bus.beq      = use_beq[i];
      bus.Zero     = use_beq[i];
      bus.PCNext   = nexts[i];
      #1;
      vectors++;
      if (bus.PCWrite !== pcw_exp[i]) begin
        miscompares++; $display("FAIL mis_pcwrite[%0d]: got %b want %b", i, bus.PCWrite, pcw_exp[i]);
      end
      clock_edge();
      e = sb_q.pop_front();
      vectors++;
      if (bus.PC !== e.pc) begin
        miscompares++; $display("FAIL mis_pc[%0d]: got %h want %h", i, bus.PC, e.pc);
      end
      vectors++;
      if (bus.Misaligned !== e.mis) begin
        miscompares++; $display("FAIL mis_flag[%0d]: got %b want %b", i, bus.Misaligned, e.mis);
      end
    end
  endtask

  task automatic test_reset_mid_op();
    snap_t e;
    @(negedge clk);
    idle_inputs();
    reset        = 1'b1;
    bus.IRWrite  = 1'b1;
    bus.beq      = 1'b1;
    bus.Zero     = 1'b1;
    bus.PCNext   = 32'h0000_0700;
    bus.ReadData = 32'h1234_5678;
    #1;
    vectors++;
    if (bus.BranchTaken !== 1'b1 || bus.PCWrite !== 1'b1) begin
      miscompares++; $display("FAIL midrst_comb: got bt=%b pcw=%b want 1/1", bus.BranchTaken, bus.PCWrite);
    end
    for (int i = 0; i < 2; i++) begin
      clock_edge();
      e = sb_q.pop_front();
      vectors++;
      if (bus.PC !== e.pc || bus.OldPC !== e.old_pc || bus.Instr !== e.instr) begin
        miscompares++;
        $display("FAIL midrst_regs[%0d]: got pc=%h old=%h ir=%h want pc=%h old=%h ir=%h", i,
                 bus.PC, bus.OldPC, bus.Instr, e.pc, e.old_pc, e.instr);
      end
      vectors++;
      if (bus.FetchCount !== e.fcnt || bus.Misaligned !== e.mis) begin
        miscompares++;
        $display("FAIL midrst_cnt[%0d]: got cnt=%h mis=%b want cnt=%h mis=%b", i,
                 bus.FetchCount, bus.Misaligned, e.fcnt, e.mis);
      end
      @(negedge clk);
      reset = 1'b0;
      idle_inputs();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    idle_inputs();
    test_reset();
    test_fetch();
    test_branches();
    test_back_to_back();
    test_counter_wrap();
    test_misaligned();
    test_reset_mid_op();
    if (sb_q.size() != 0) begin
      miscompares++;
      $display("FAIL scoreboard_drain: got %0d entries left want 0", sb_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
